// File: rtl/dlfloat_mac_host_driver.sv
// dlfloat_mac_host_driver
//   Host-side driver for the DLFloat16 MAC tile. Accepts operand pairs over a
//   valid/ready handshake, drives operand A then operand B onto the tile's
//   16 input pins, waits MAC_LAT cycles, then collects the result from the
//   8-bit uo_out bus (low byte, then high byte) and returns it over a
//   valid/ready handshake. Data bits are never altered.
//
//   Optional feature macro: DLFMAC_SKID_EN
//     defined   : 2-entry result FIFO, back-to-back frames while space remains
//     undefined : single result register, strict ping-pong with the consumer
module dlfloat_mac_host_driver #(
  parameter int unsigned MAC_LAT   = 3,        // B-drive cycle to low-result-byte cycle (>=1)
  parameter logic [15:0] IDLE_WORD = 16'h0000  // pin value outside DRV_A/DRV_B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [7:0]  pin_ui,
  output logic [7:0]  pin_uio,
  output logic        pin_ena,
  input  logic [7:0]  pin_uo,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRV_A,
    S_DRV_B,
    S_WAIT,
    S_CAP_LO,
    S_CAP_HI
  } state_e;

  // Wide enough to hold MAC_LAT-1 (the WAIT-phase reload value).
  localparam int unsigned CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_e           state_q;
  logic [15:0]      pins_q;
  logic [15:0]      op_b_q;
  logic             ena_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic consume;
  logic space_ok;

  assign accept   = in_valid && in_ready;
  assign consume  = res_valid && res_ready;
  assign in_ready = (state_q == S_IDLE) && space_ok;
  assign busy     = (state_q != S_IDLE);

  // Pins come straight from registers: no combinational host-to-tile path.
  assign pin_ui  = pins_q[7:0];
  assign pin_uio = pins_q[15:8];
  assign pin_ena = ena_q;

  // Frame sequencer: drives operands, times the MAC latency, marks capture cycles.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pins_q  <= IDLE_WORD;
      op_b_q  <= '0;
      ena_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            // A goes straight to the pins; only B needs to be held for a cycle.
            pins_q  <= op_a;
            op_b_q  <= op_b;
            ena_q   <= 1'b1;
            state_q <= S_DRV_A;
          end
        end
        S_DRV_A: begin
          pins_q  <= op_b_q;
          state_q <= S_DRV_B;
        end
        S_DRV_B: begin
          pins_q  <= IDLE_WORD;
          cnt_q   <= CNT_W'(MAC_LAT - 1);
          state_q <= (MAC_LAT == 1) ? S_CAP_LO : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_CAP_LO;
        end
        S_CAP_LO: begin
          state_q <= S_CAP_HI;
        end
        S_CAP_HI: begin
          ena_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DLFMAC_SKID_EN

  logic [7:0]  lo_q;
  logic [15:0] fifo_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        push;

  // A frame is only accepted while a slot is free and occupancy can only fall
  // during the frame, so the push at CAP_HI always finds room.
  assign push      = (state_q == S_CAP_HI);
  assign space_ok  = (count_q != 2'd2);
  assign res_valid = (count_q != 2'd0);
  assign res_data  = fifo_q[rd_ptr_q];

  // Two-entry result FIFO; the low byte is staged until the high byte arrives.
  // NOTE: the storage is reset as well, so res_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q      <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (state_q == S_CAP_LO) lo_q <= pin_uo;
      if (push) begin
        fifo_q[wr_ptr_q] <= {pin_uo, lo_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (consume) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, consume};
    end
  end

`else

  logic [15:0] res_q;
  logic        res_valid_q;

  assign space_ok  = !res_valid_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;

  // Single result register; a new frame cannot start until this one is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (state_q == S_CAP_LO) res_q[7:0] <= pin_uo;
      if (state_q == S_CAP_HI) begin
        res_q[15:8] <= pin_uo;
        res_valid_q <= 1'b1;
      end else if (consume) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`endif

endmodule
